tetris_cell_drawer: RTL and testbench
=====================================

# tetris_cell_drawer

Pixel-stream generator that sits directly upstream of the VGA address translator and frame-buffer write port. It accepts one draw command at a time: either fill one Tetris board cell, or clear the full screen. It then emits one (x, y, colour, plot) pixel write per clock in raster order. The x/y outputs connect straight to the translator's coordinate inputs at 320x240 resolution.

## Interface
- `CELL`, 10: cell edge length in pixels.
- `COLS`, 10: board columns.
- `ROWS`, 20: board rows.
- `X0`, 110: board left edge, in pixels.
- `Y0`, 20: board top edge, in pixels.
- `COLOR_W`, 9: colour width.
- `BORDER_COLOR`, 9'h000: edge colour; used only when `CELL_BORDER_EN` is defined.
- `clock` in 1: single clock; all logic is on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `req_valid` in 1: command present.
- `req_ready` out 1: block can accept a command.
- `req_clear` in 1: 1 = clear the whole screen; 0 = draw a cell.
- `req_col` in 4: cell column.
- `req_row` in 5: cell row.
- `req_color` in COLOR_W: fill colour, or clear colour.
- `x` out 9: pixel x, range 0..319.
- `y` out 8: pixel y, range 0..239.
- `color` out COLOR_W: pixel colour.
- `plot` out 1: write strobe; x/y/color are valid when it is high.
- `done` out 1: one-cycle pulse when a command completes.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - CELL: `req_ready`=0.
  - CLEAR: `req_ready`=0.
  - FINISH: `req_ready`=0.
- Accept a command when `req_valid` & `req_ready` are both high at a clock edge. The command fields are latched at that edge.
- Next state after accept:
  - `req_clear`=1 → CLEAR.
  - `req_clear`=0 with an in-range cell → CELL.
  - `req_col`≥COLS or `req_row`≥ROWS → FINISH, with no pixels emitted.
- CELL:
  - Pixel position: x = X0 + col·CELL + dx; y = Y0 + row·CELL + dy.
  - dx is the fastest-moving index, 0..CELL-1; dy increments when dx wraps.
  - Arithmetic is unsigned and computed in 9/8 bits; defaults never overflow (max x=209, max y=219).
  - After pixel (CELL-1, CELL-1) → FINISH.
- CLEAR:
  - x runs 0..319 fastest, then y runs 0..239.
  - colour = `req_color` for every pixel; the border never applies.
  - After pixel (319, 239) → FINISH.
- FINISH: `done`=1 for one cycle, `plot`=0, then → IDLE.
- `req_valid` while busy is ignored. The requester must hold it until `req_ready` is high.
- Reset in any state aborts immediately; no residual `plot` is emitted.

## Timing
- Reset values: `x`=0, `y`=0, `color`=0, `plot`=0, `done`=0, `req_ready`=1, state = IDLE.
- All outputs are registered.
- Accept at edge N → first pixel (plot=1) is visible after edge N+1.
- Pixel throughput is one per cycle, with no bubbles.
- Cell command:
  - plot high for exactly CELL² = 100 consecutive cycles.
  - `done` in the cycle after the last pixel.
  - `req_ready` returns high together with... the cycle after `done`; the next accept occurs no earlier than 102 cycles after the previous one.
- Clear command: plot high for 76800 consecutive cycles, then `done`.
- Out-of-range cell: `done` is visible after edge N+1, with plot=0.
- Assertion of `resetn`=0 at edge M → all reset values are visible after edge M, even mid-stream.

## Configuration
- `CELL_BORDER_EN`:
  - Defined: CELL pixels with dx∈{0, CELL-1} or dy∈{0, CELL-1} output `BORDER_COLOR`; interior pixels output `req_color`.
  - Undefined: every CELL pixel outputs `req_color`; the border compare logic is absent.
  - Cycle counts and CLEAR behaviour are identical either way.

## Structure
- Shared package `tetris_vga_pkg` holds:
  - screen constants `SCR_W`=320, `SCR_H`=240, `X_W`=9, `Y_W`=8;
  - board constants `CELL`, `COLS`, `ROWS`, `X0`, `Y0`;
  - the state enum typedef `draw_state_t`.
- One sub-module, `raster_counter`, is natural:
  - loadable (dx, dy) counter with programmable width/height limits;
  - `step` input; `last` output.
  - Used by both CELL (limits CELL×CELL) and CLEAR (limits 320×240).

## Test plan
- Reset, then idle → `req_ready`=1, `plot`=0, x=y=0.
- Cell col=0, row=0, colour=9'h1C0:
  - 100 plots;
  - first (110,20), last (119,29);
  - `done` 1 cycle after the last plot.
- Cell col=9, row=19 → first pixel (200,210), last (209,219); `req_ready` low throughout.
- Clear, colour=9'h000:
  - 76800 plots;
  - first (0,0), pixel 320 at (0,1), last (319,239);
  - then `done`.
- Cell col=12 → zero plots; `done` at N+1; ready again at N+2.
- `resetn` low at pixel 50 of a cell → plot=0 and outputs zero next cycle; a new command is accepted right after reset release.
- With `CELL_BORDER_EN` defined: the interior pixel (115,25) gets `req_color`; the edge pixel (110,25) gets `BORDER_COLOR`.

Source files
------------

// File: rtl/tetris_vga_pkg.sv
// Shared constants and types for the Tetris VGA drawing path.
//   Screen: SCR_W x SCR_H pixels, coordinates X_W / Y_W bits wide.
//   Board:  COLS x ROWS cells of CELL x CELL pixels, top-left corner at (X0, Y0).
//   draw_state_t: state encoding of the cell/clear pixel generator.
package tetris_vga_pkg;

  localparam int SCR_W = 320;
  localparam int SCR_H = 240;
  localparam int X_W   = 9;
  localparam int Y_W   = 8;

  localparam int CELL  = 10;
  localparam int COLS  = 10;
  localparam int ROWS  = 20;
  localparam int X0    = 110;
  localparam int Y0    = 20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CELL   = 2'd1,
    ST_CLEAR  = 2'd2,
    ST_FINISH = 2'd3
  } draw_state_t;

endpackage

// File: rtl/raster_counter.sv
// Loadable two-dimensional raster counter.
//   load        : clear (dx, dy) to (0, 0) and latch the inclusive limits w_max / h_max
//   step        : advance one position, dx fastest, dy increments when dx wraps
//   dx, dy      : current position
//   last        : current position is (w_max, h_max)
// Synchronous active-low reset clears position and limits.
module raster_counter #(
  parameter int XW = 9,
  parameter int YW = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          load,
  input  logic          step,
  input  logic [XW-1:0] w_max,
  input  logic [YW-1:0] h_max,
  output logic [XW-1:0] dx,
  output logic [YW-1:0] dy,
  output logic          last
);

  logic [XW-1:0] w_lim;
  logic [YW-1:0] h_lim;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dx    <= '0;
      dy    <= '0;
      w_lim <= '0;
      h_lim <= '0;
    end else if (load) begin
      dx    <= '0;
      dy    <= '0;
      w_lim <= w_max;
      h_lim <= h_max;
    end else if (step) begin
      if (dx == w_lim) begin
        dx <= '0;
        dy <= dy + YW'(1);
      end else begin
        dx <= dx + XW'(1);
      end
    end
  end

  assign last = (dx == w_lim) && (dy == h_lim);

endmodule

// File: rtl/tetris_cell_drawer.sv
// Pixel-stream generator feeding the VGA address translator / frame-buffer write port.
// Accepts one command at a time (fill one board cell, or clear the whole screen) and
// emits one registered (x, y, color, plot) pixel write per clock in raster order.
//
// Ports:
//   clock, resetn        : rising-edge clock, synchronous active-low reset
//   req_valid/req_ready  : command handshake
//   req_clear            : 1 = clear screen with req_color, 0 = fill cell (req_col, req_row)
//   req_col, req_row     : cell coordinates (out-of-range -> no pixels, just done)
//   req_color            : fill / clear colour
//   x, y, color, plot    : pixel write, valid while plot is high
//   done                 : one-cycle pulse after a command's last pixel
//   dbg_state            : current FSM state (draw_state_t encoding)
//
// Handshake: a command is taken on a rising edge where req_valid and req_ready are
// both high; its fields are captured on that edge. req_valid seen while req_ready is
// low is ignored, so the requester holds the command until req_ready is high.
//
// Optional macro CELL_BORDER_EN: when defined, cell pixels on the outer ring of the
// cell use BORDER_COLOR instead of req_color. Clears are never bordered.
module tetris_cell_drawer
  import tetris_vga_pkg::*;
#(
  parameter int                 CELL         = tetris_vga_pkg::CELL,
  parameter int                 COLS         = tetris_vga_pkg::COLS,
  parameter int                 ROWS         = tetris_vga_pkg::ROWS,
  parameter int                 X0           = tetris_vga_pkg::X0,
  parameter int                 Y0           = tetris_vga_pkg::Y0,
  parameter int                 COLOR_W      = 9,
  parameter logic [COLOR_W-1:0] BORDER_COLOR = '0
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_clear,
  input  logic [3:0]         req_col,
  input  logic [4:0]         req_row,
  input  logic [COLOR_W-1:0] req_color,
  output logic [8:0]         x,
  output logic [7:0]         y,
  output logic [COLOR_W-1:0] color,
  output logic               plot,
  output logic               done,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_CELL   = ST_CELL;
  localparam logic [1:0] S_CLEAR  = ST_CLEAR;
  localparam logic [1:0] S_FINISH = ST_FINISH;

  logic [1:0]         state;
  logic [COLOR_W-1:0] cmd_color;
  logic [8:0]         base_x;
  logic [7:0]         base_y;

  logic               accept;
  logic               in_range;
  logic [8:0]         cell_x;
  logic [7:0]         cell_y;
  logic [8:0]         w_max;
  logic [7:0]         h_max;
  logic               step;
  logic [8:0]         dx;
  logic [7:0]         dy;
  logic               last;
  logic [COLOR_W-1:0] cell_pix_color;

  assign accept   = (state == S_IDLE) && req_valid && req_ready;
  assign in_range = (32'(req_col) < COLS) && (32'(req_row) < ROWS);
  assign cell_x   = 9'(X0) + 9'(req_col) * 9'(CELL);
  assign cell_y   = 8'(Y0) + 8'(req_row) * 8'(CELL);
  assign w_max    = req_clear ? 9'(SCR_W - 1) : 9'(CELL - 1);
  assign h_max    = req_clear ? 8'(SCR_H - 1) : 8'(CELL - 1);
  assign step     = (state == S_CELL) || (state == S_CLEAR);

  raster_counter #(
    .XW(9),
    .YW(8)
  ) u_raster (
    .clock (clock),
    .resetn(resetn),
    .load  (accept),
    .step  (step),
    .w_max (w_max),
    .h_max (h_max),
    .dx    (dx),
    .dy    (dy),
    .last  (last)
  );

`ifdef CELL_BORDER_EN
  logic on_edge;
  assign on_edge = (dx == 9'd0) || (dx == 9'(CELL - 1)) ||
                   (dy == 8'd0) || (dy == 8'(CELL - 1));
  assign cell_pix_color = on_edge ? BORDER_COLOR : cmd_color;
`else
  assign cell_pix_color = cmd_color;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      x         <= '0;
      y         <= '0;
      color     <= '0;
      plot      <= 1'b0;
      done      <= 1'b0;
      cmd_color <= '0;
      base_x    <= '0;
      base_y    <= '0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cmd_color <= req_color;
            base_x    <= cell_x;
            base_y    <= cell_y;
            req_ready <= 1'b0;
            if (req_clear)     state <= S_CLEAR;
            else if (in_range) state <= S_CELL;
            else               state <= S_FINISH;
          end else begin
            // Re-opens the handshake one cycle after the done pulse.
            req_ready <= 1'b1;
          end
        end
        S_CELL: begin
          x     <= base_x + dx;
          y     <= base_y + dy;
          color <= cell_pix_color;
          plot  <= 1'b1;
          if (last) state <= S_FINISH;
        end
        S_CLEAR: begin
          x     <= dx;
          y     <= dy;
          color <= cmd_color;
          plot  <= 1'b1;
          if (last) state <= S_FINISH;
        end
        S_FINISH: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_tetris_cell_drawer.sv
module tb_tetris_cell_drawer;

  localparam logic [8:0] BORDER = 9'h000;

  logic       clock;
  logic       resetn;
  logic       req_valid;
  logic       req_ready;
  logic       req_clear;
  logic [3:0] req_col;
  logic [4:0] req_row;
  logic [8:0] req_color;
  logic [8:0] x;
  logic [7:0] y;
  logic [8:0] color;
  logic       plot;
  logic       done;
  logic [1:0] dbg_state;

  tetris_cell_drawer dut (
    .clock    (clock),
    .resetn   (resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_clear(req_clear),
    .req_col  (req_col),
    .req_row  (req_row),
    .req_color(req_color),
    .x        (x),
    .y        (y),
    .color    (color),
    .plot     (plot),
    .done     (done),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard: {x, y, color}
  logic [25:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [25:0] pack(input int px, input int py, input logic [8:0] c);
    pack = {9'(px), 8'(py), c};
  endfunction

  task automatic push_expected(input logic clr, input int col, input int row,
                               input logic [8:0] c);
    logic [8:0] pc;
    if (clr) begin
      for (int py = 0; py < 240; py++)
        for (int px = 0; px < 320; px++)
          exp_q.push_back(pack(px, py, c));
    end else if (col < 10 && row < 20) begin
      for (int dy = 0; dy < 10; dy++)
        for (int dx = 0; dx < 10; dx++) begin
          pc = c;
`ifdef CELL_BORDER_EN
          if (dx == 0 || dx == 9 || dy == 0 || dy == 9) pc = BORDER;
`endif
          exp_q.push_back(pack(110 + col * 10 + dx, 20 + row * 10 + dy, pc));
        end
    end
  endtask

  // compare one plotted pixel against the head of the scoreboard
  task automatic score_pixel();
    logic [25:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL pixel: unexpected plot at (%0d,%0d) color %h", x, y, color);
    end else begin
      e = exp_q.pop_front();
      if (e != {x, y, color}) begin
        n_fail++;
        if (n_fail <= 30)
          $display("FAIL pixel: got (%0d,%0d,%h) expected (%0d,%0d,%h)",
                   x, y, color, e[25:17], e[16:9], e[8:0]);
      end
    end
  endtask

  // driver: wait for ready, present one command, follow it to done
  task automatic run_cmd(input string tag, input logic clr, input int col, input int row,
                         input logic [8:0] c, input int exp_plots,
                         input int fx, input int fy, input int lx, input int ly);
    int w, first_k, last_k, done_k, plots, ready_err, afx, afy, alx, aly;
    w = 0;
    while (!req_ready && w < 200) begin
      @(negedge clock);
      w++;
    end
    check({tag, "_ready_before"}, int'(req_ready), 1);
    req_valid = 1'b1;
    req_clear = clr;
    req_col   = 4'(col);
    req_row   = 5'(row);
    req_color = c;
    push_expected(clr, col, row, c);
    @(posedge clock);
    @(negedge clock);
    // Busy-time requests must be ignored.
    req_clear = 1'b0;
    req_col   = 4'($urandom_range(0, 9));
    req_row   = 5'($urandom_range(0, 19));
    req_color = 9'($urandom_range(0, 511));
    check({tag, "_plot_at_accept"}, int'(plot), 0);
    check({tag, "_ready_low"}, int'(req_ready), 0);
    first_k = -1; last_k = -1; done_k = -1; plots = 0; ready_err = 0;
    afx = -1; afy = -1; alx = -1; aly = -1;
    for (int k = 1; k <= 80000 && done_k < 0; k++) begin
      @(negedge clock);
      if (req_ready) ready_err++;
      if (plot) begin
        score_pixel();
        if (first_k < 0) begin
          first_k = k; afx = int'(x); afy = int'(y);
        end
        last_k = k; alx = int'(x); aly = int'(y);
        plots++;
      end
      if (done) begin
        done_k = k;
        req_valid = 1'b0;
        check({tag, "_plot_with_done"}, int'(plot), 0);
      end
    end
    req_valid = 1'b0;
    check({tag, "_done_seen"}, int'(done_k > 0), 1);
    check({tag, "_plots"}, plots, exp_plots);
    check({tag, "_ready_while_busy"}, ready_err, 0);
    if (exp_plots > 0) begin
      check({tag, "_first_latency"}, first_k, 1);
      check({tag, "_no_bubbles"}, last_k - first_k + 1, plots);
      check({tag, "_done_after_last"}, done_k, last_k + 1);
      check({tag, "_first_x"}, afx, fx);
      check({tag, "_first_y"}, afy, fy);
      check({tag, "_last_x"}, alx, lx);
      check({tag, "_last_y"}, aly, ly);
    end else begin
      check({tag, "_done_latency"}, done_k, 1);
    end
    @(negedge clock);
    check({tag, "_done_one_cycle"}, int'(done), 0);
    check({tag, "_ready_back"}, int'(req_ready), 1);
    check({tag, "_plot_idle"}, int'(plot), 0);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  typedef struct {
    string      tag;
    logic       clr;
    int         col;
    int         row;
    logic [8:0] c;
    int         exp_plots;
    int         fx, fy, lx, ly;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int plots, w;

    vecs[0] = '{"cell_0_0",   1'b0, 0,  0,  9'h1C0, 100,   110, 20,  119, 29};
    vecs[1] = '{"cell_9_19",  1'b0, 9,  19, 9'h03F, 100,   200, 210, 209, 219};
    vecs[2] = '{"cell_3_7",   1'b0, 3,  7,  9'h155, 100,   140, 90,  149, 99};
    vecs[3] = '{"cell_col12", 1'b0, 12, 0,  9'h1FF, 0,     0,   0,   0,   0};
    vecs[4] = '{"cell_row20", 1'b0, 2,  20, 9'h0AA, 0,     0,   0,   0,   0};
    vecs[5] = '{"clear",      1'b1, 0,  0,  9'h000, 76800, 0,   0,   319, 239};

    resetn = 1'b0; req_valid = 1'b0; req_clear = 1'b0;
    req_col = '0; req_row = '0; req_color = '0;
    repeat (3) @(negedge clock);
    check("rst_ready", int'(req_ready), 1);
    check("rst_plot", int'(plot), 0);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_color", int'(color), 0);
    check("rst_done", int'(done), 0);
    check("rst_state", int'(dbg_state), 0);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_ready", int'(req_ready), 1);
    check("idle_plot", int'(plot), 0);
    check("idle_x", int'(x), 0);
    check("idle_y", int'(y), 0);

    for (int i = 0; i < 6; i++)
      run_cmd(vecs[i].tag, vecs[i].clr, vecs[i].col, vecs[i].row, vecs[i].c,
              vecs[i].exp_plots, vecs[i].fx, vecs[i].fy, vecs[i].lx, vecs[i].ly);

    // reset in the middle of a cell stream
    check("mid_ready_before", int'(req_ready), 1);
    req_valid = 1'b1; req_clear = 1'b0; req_col = 4'd4; req_row = 5'd5; req_color = 9'h0F0;
    push_expected(1'b0, 4, 5, 9'h0F0);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    plots = 0; w = 0;
    while (plots < 50 && w < 200) begin
      @(negedge clock);
      w++;
      if (plot) begin
        score_pixel();
        plots++;
      end
    end
    check("mid_plots_reached", plots, 50);
    resetn = 1'b0;
    @(negedge clock);
    check("mid_rst_plot", int'(plot), 0);
    check("mid_rst_x", int'(x), 0);
    check("mid_rst_y", int'(y), 0);
    check("mid_rst_color", int'(color), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_ready", int'(req_ready), 1);
    check("mid_rst_state", int'(dbg_state), 0);
    exp_q.delete();
    resetn = 1'b1;
    run_cmd("after_rst", 1'b0, 1, 2, 9'h111, 100, 120, 40, 129, 49);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
